// File: rtl/tdes_key_sched_ctrl.sv
// Triple-DES key schedule sequencer.
// Steps three PC-1 keys through 3 stages x 16 rounds and hands each rotated {C,D}
// round key to the PC-2/round datapath over a valid/ready handshake.
// Optional feature macro: KEY_SCHED_DECRYPT_EN adds the mode_i port (TDES decrypt
// ordering). Without it the block is fixed at EDE encrypt ordering.
module tdes_key_sched_ctrl (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
`ifdef KEY_SCHED_DECRYPT_EN
  input  logic        mode_i,
`endif
  input  logic [55:0] cd1_i,
  input  logic [55:0] cd2_i,
  input  logic [55:0] cd3_i,
  input  logic        round_ready_i,
  output logic [55:0] round_key_cd_o,
  output logic        round_valid_o,
  output logic [3:0]  round_num_o,
  output logic [1:0]  stage_o,
  output logic        stage_decrypt_o,
  output logic        stage_done_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {StIdle, StRound, StStageEnd, StDone} state_e;

  state_e      state_q;
  logic [55:0] k1_q, k2_q, k3_q, key_q;
  logic        mode_q, dec_q, valid_q, sd_q, busy_q, done_q;
  logic [3:0]  round_q;
  logic [1:0]  stage_q;

  logic        mode_w;
`ifdef KEY_SCHED_DECRYPT_EN
  assign mode_w = mode_i;
`else
  assign mode_w = 1'b0;
`endif

  // True where the shift schedule SH[idx] (1-based) is a single-bit rotation.
  function automatic logic sh_one(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16);
  endfunction

  // Rotate both 28-bit halves left by 1 or 2.
  function automatic logic [55:0] rot_l(input logic [55:0] cd, input logic two);
    return two ? {cd[53:28], cd[55:54], cd[25:0], cd[27:26]}
               : {cd[54:28], cd[55], cd[26:0], cd[27]};
  endfunction

  // Rotate both 28-bit halves right by 1 or 2.
  function automatic logic [55:0] rot_r(input logic [55:0] cd, input logic two);
    return two ? {cd[29:28], cd[55:30], cd[1:0], cd[27:2]}
               : {cd[28], cd[55:29], cd[0], cd[27:1]};
  endfunction

  // Round-0 key: encrypt rotates by SH[1]=1, decrypt presents the loaded key as is.
  function automatic logic [55:0] first_key(input logic [55:0] cd, input logic dec);
    return dec ? cd : rot_l(cd, 1'b0);
  endfunction

  // Next stage's source key and direction, used when leaving StStageEnd.
  logic [1:0]  nxt_stage;
  logic [55:0] nxt_src;
  logic        nxt_dec;
  logic        enc_two, dec_two;

  // Stage selection and per-round shift amounts derived from registered state only.
  always_comb begin
    nxt_stage = stage_q + 2'd1;
    nxt_dec   = (nxt_stage == 2'd1) ^ mode_q;
    if (nxt_stage == 2'd1) begin
      nxt_src = k2_q;
    end else begin
      nxt_src = mode_q ? k1_q : k3_q;
    end
    // Moving to round r+1: encrypt uses SH[r+2], decrypt uses SH[16-r].
    enc_two = !sh_one({1'b0, round_q} + 5'd2);
    dec_two = !sh_one(5'd16 - {1'b0, round_q});
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= StIdle;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      round_q <= '0;
      stage_q <= '0;
    end else begin
      sd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            k1_q    <= cd1_i;
            k2_q    <= cd2_i;
            k3_q    <= cd3_i;
            mode_q  <= mode_w;
            // Stage 0 is cd1 encrypt in EDE, cd3 decrypt in reverse ordering.
            key_q   <= first_key(mode_w ? cd3_i : cd1_i, mode_w);
            dec_q   <= mode_w;
            round_q <= '0;
            stage_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StRound;
          end
        end
        StRound: begin
          if (round_ready_i) begin
            if (round_q != 4'd15) begin
              round_q <= round_q + 4'd1;
              key_q   <= dec_q ? rot_r(key_q, dec_two) : rot_l(key_q, enc_two);
            end else begin
              valid_q <= 1'b0;
              sd_q    <= 1'b1;
              if (stage_q == 2'd2) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                state_q <= StStageEnd;
              end
            end
          end
        end
        StStageEnd: begin
          stage_q <= nxt_stage;
          round_q <= '0;
          dec_q   <= nxt_dec;
          key_q   <= first_key(nxt_src, nxt_dec);
          valid_q <= 1'b1;
          state_q <= StRound;
        end
        StDone: begin
          round_q <= '0;
          stage_q <= '0;
          dec_q   <= 1'b0;
          key_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign round_key_cd_o  = key_q;
  assign round_valid_o   = valid_q;
  assign round_num_o     = round_q;
  assign stage_o         = stage_q;
  assign stage_decrypt_o = dec_q;
  assign stage_done_o    = sd_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
